// File: rtl/par_pkg.sv
// Shared definitions for the 3-bit odd-parity serial link.
// Holds the FSM state encoding and the default bit period, used by both the
// receiver (parity_rx_3b) and the matching transmitter.
package par_pkg;

    // Default number of clk cycles per serial bit.
    localparam int CLKS_PER_BIT_DEF = 4;

    // Number of data bits in a frame.
    localparam int DATA_BITS = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } par_state_t;

endpackage

// File: rtl/xnor_i3.sv
// Three-input XNOR gate. The receiver uses it to form the expected odd-parity
// bit from the three received data bits.
// Ports:
//   a, b, c : gate inputs
//   y       : ~(a ^ b ^ c)
module xnor_i3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = ~(a ^ b ^ c);

endmodule

// File: rtl/parity_rx_3b.sv
// Serial receiver for frames of: start(0), d0, d1, d2, odd parity, stop(1).
// Every bit lasts CLKS_PER_BIT clk cycles. Bits are sampled near their middle,
// and the received frame is held behind a valid/ready handshake.
// Ports:
//   clk      : sole clock, rising edge
//   reset    : synchronous, active-high reset
//   rx       : serial line, idle high, already synchronous to clk
//   data     : received data bits d2..d0
//   par_err  : received parity differs from the expected odd parity
//   frm_err  : stop bit was sampled low
//   valid    : data/par_err/frm_err hold a frame not yet accepted
//   ready    : consumer accepts the held frame when valid & ready
//   overrun  : a new frame overwrote an unaccepted frame; sticky until handshake
//
// state  | meaning
// IDLE   | line idle, looking for rx = 0 (start edge)
// START  | waiting for the middle of the start bit to confirm it
// DATA   | sampling d0..d2 one bit period apart
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, frame delivered at this sample
// BREAK  | stop bit was low; waiting for rx = 1 before re-arming start detect
module parity_rx_3b
    import par_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [2:0] data,
    output logic       par_err,
    output logic       frm_err,
    output logic       valid,
    input  logic       ready,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Down-counter reload values: half a bit period to reach the start-bit
    // middle, then a full bit period between subsequent samples.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    par_state_t      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      bit_idx, bit_idx_nxt;
    logic [2:0]      shift, shift_nxt;
    logic            par_bit, par_bit_nxt;
    logic            load;
    logic            par_exp;
    logic            cnt_zero;

    assign cnt_zero = (cnt == '0);

    xnor_i3 u_par_exp (
        .a (shift[0]),
        .b (shift[1]),
        .c (shift[2]),
        .y (par_exp)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        par_bit_nxt = par_bit;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (!rx) begin
                    state_nxt   = START;
                    cnt_nxt     = HALF_LAST;
                    bit_idx_nxt = 2'd0;
                end
            end

            START: begin
                if (cnt_zero) begin
                    // A high line at mid start bit was only a glitch.
                    state_nxt = rx ? IDLE : DATA;
                    cnt_nxt   = BIT_LAST;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            DATA: begin
                if (cnt_zero) begin
                    // LSB arrives first, so shift in from the top.
                    shift_nxt = {rx, shift[2:1]};
                    cnt_nxt   = BIT_LAST;
                    if (bit_idx == 2'(DATA_BITS - 1)) begin
                        state_nxt = PARITY;
                    end else begin
                        bit_idx_nxt = bit_idx + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            PARITY: begin
                if (cnt_zero) begin
                    par_bit_nxt = rx;
                    cnt_nxt     = BIT_LAST;
                    state_nxt   = STOP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            STOP: begin
                if (cnt_zero) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = rx ? IDLE : BREAK;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            BREAK: begin
                if (rx) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 2'd0;
            shift   <= 3'b000;
            par_bit <= 1'b0;
            data    <= 3'b000;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            par_bit <= par_bit_nxt;

            if (load) begin
                data    <= shift;
                par_err <= par_bit ^ par_exp;
                frm_err <= ~rx;
                valid   <= 1'b1;
                // Overwriting an unaccepted frame is an overrun; a load that
                // coincides with the handshake replaces the frame cleanly.
                overrun <= valid & ~ready;
            end else if (valid && ready) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_rx_3b.sv
module tb_parity_rx_3b;

    localparam int C = 4;
    localparam int H = C / 2;
    localparam int LAT = H + 5 * C + 1;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [2:0] data;
    logic       par_err;
    logic       frm_err;
    logic       valid;
    logic       ready;
    logic       overrun;

    parity_rx_3b #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .data    (data),
        .par_err (par_err),
        .frm_err (frm_err),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun)
    );

    typedef struct {
        logic [2:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
        int         t;    // cycle in which valid must first show; -1 = untimed
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: odd parity means data plus parity must contain an odd
    // number of ones.
    function automatic exp_t model(input logic [2:0] d, input logic p, input logic s,
                                   input logic ov, input int t);
        exp_t e;
        int ones;
        ones = int'(d[0]) + int'(d[1]) + int'(d[2]) + int'(p);
        e.d  = d;
        e.pe = (ones % 2 == 0);
        e.fe = (s == 1'b0);
        e.ov = ov;
        e.t  = t;
        return e;
    endfunction

    function automatic logic good_par(input logic [2:0] d);
        int ones;
        ones = int'(d[0]) + int'(d[1]) + int'(d[2]);
        return (ones % 2 == 0);
    endfunction

    // Monitor: pops an expected frame at every handshake.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got data %0h with nothing expected (cycle %0d)", data, cyc);
            end else begin
                mon_e = q.pop_front();
                check("data", 32'(data), 32'(mon_e.d));
                check("par_err", 32'(par_err), 32'(mon_e.pe));
                check("frm_err", 32'(frm_err), 32'(mon_e.fe));
                check("overrun", 32'(overrun), 32'(mon_e.ov));
                if (mon_e.t >= 0) check("latency", 32'(cyc), 32'(mon_e.t));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1 rx = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        repeat (n) begin
            @(posedge clk); #1 rx = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p, input logic s,
                              input bit push, input logic ov, input bit timed);
        logic [5:0] bits;
        int t0;
        bits = {s, p, d[2], d[1], d[0], 1'b0};
        @(posedge clk); #1 rx = bits[0];
        t0 = cyc;
        if (push) q.push_back(model(d, p, s, ov, timed ? t0 + LAT : -1));
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < C; c++) begin
                if (i != 0 || c != 0) begin
                    @(posedge clk); #1 rx = bits[i];
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d frames pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [2:0] d;
        logic       p;
        logic       s;

        rx    = 1'b1;
        ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_flags", 32'({par_err, frm_err, overrun}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        idle(3);

        // Clean frame, bad parity, then bad stop held low into a break.
        send_frame(3'b101, 1'b1, 1'b1, 1, 1'b0, 1);
        idle(2);
        send_frame(3'b101, 1'b0, 1'b1, 1, 1'b0, 1);
        idle(2);
        send_frame(3'b101, 1'b1, 1'b0, 1, 1'b0, 1);
        hold_low(8);
        idle(2);
        send_frame(3'b010, 1'b0, 1'b1, 1, 1'b0, 1);
        idle(2);

        // False start: one low cycle, then high.
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 rx = 1'b1;
            @(negedge clk);
            check("false_start_valid", 32'(valid), 32'd0);
        end

        // Overrun: two frames with nobody accepting.
        ready = 1'b0;
        send_frame(3'b011, 1'b1, 1'b1, 0, 1'b0, 0);
        send_frame(3'b110, 1'b1, 1'b1, 1, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(valid), 32'd1);
            check("hold_data", 32'(data), 32'b110);
            check("hold_overrun", 32'(overrun), 32'd1);
            @(posedge clk); #1 rx = 1'b1;
        end
        ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        check("ack_valid", 32'(valid), 32'd0);
        check("ack_overrun", 32'(overrun), 32'd0);

        // Load coinciding with handshake: no overrun.
        send_frame(3'b010, 1'b0, 1'b1, 1, 1'b0, 0);
        fork
            send_frame(3'b111, 1'b0, 1'b1, 1, 1'b0, 0);
            begin
                @(posedge clk);
                repeat (22) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk); #1 ready = 1'b0;
            end
        join
        @(negedge clk);
        check("same_cycle_valid", 32'(valid), 32'd1);
        check("same_cycle_data", 32'(data), 32'b111);
        check("same_cycle_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1 begin rx = 1'b1; ready = 1'b1; end
        @(posedge clk); #1 ready = 1'b0;

        // Reset mid-frame discards the partial frame and the held one.
        send_frame(3'b100, 1'b0, 1'b1, 0, 1'b0, 0);
        idle(2);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1 rx = (i >= C && i < 2 * C) ? 1'b1 : 1'b0;
        end
        @(posedge clk); #1 begin reset = 1'b1; rx = 1'b1; end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_flags", 32'({par_err, frm_err, overrun}), 32'd0);
        ready = 1'b1;
        idle(30);
        send_frame(3'b011, 1'b0, 1'b1, 1, 1'b0, 1);
        idle(2);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                hold_low($urandom_range(1, H));
                idle(4);
            end else begin
                d = 3'($urandom_range(0, 7));
                p = good_par(d);
                if ($urandom_range(0, 3) == 0) p = ~p;
                s = ($urandom_range(0, 5) != 0);
                send_frame(d, p, s, 1, 1'b0, 1);
                if (!s) begin
                    hold_low($urandom_range(0, 8));
                    idle($urandom_range(1, 3));
                end else begin
                    idle($urandom_range(0, 3));
                end
            end
        end

        wait_drain(100);
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parity_rx_3b.md
PARITY_RX_3B -- requirements
Module: parity_rx_3b

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit; legal values >= 2.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rx  in  1  serial line, idle high, synchronous to clk; no internal synchronizer.
REQ-005 data  out  3  received data bits d2..d0.
REQ-006 par_err  out  1  received parity bit differs from the expected odd-parity bit for data.
REQ-007 frm_err  out  1  stop bit was sampled low.
REQ-008 valid  out  1  data, par_err and frm_err hold a frame not yet accepted.
REQ-009 ready  in  1  consumer accepts the held frame when valid and ready are both high in a cycle.
REQ-010 overrun  out  1  a completed frame overwrote an unaccepted frame.

Function
REQ-011 Frame format SHALL be: start (0), d0, d1, d2 (LSB first), parity p, stop (1), each lasting CLKS_PER_BIT cycles.
REQ-012 Expected parity SHALL be ~(d0 ^ d1 ^ d2), which is odd parity over the data and parity bits together.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-014 IDLE -> START SHALL occur at the first cycle T0 in which rx = 0; the bit counter clears at that cycle.
REQ-015 In START, rx SHALL be resampled at T0+H, where H = CLKS_PER_BIT/2 (integer division).
REQ-016 If the START resample reads 1, the frame is a false start: the FSM returns to IDLE with no output change.
REQ-017 Data bit i SHALL be sampled at T0+H+(i+1)*CLKS_PER_BIT, parity at T0+H+4*CLKS_PER_BIT, and stop at T0+H+5*CLKS_PER_BIT.
REQ-018 The cycle after the stop sample, data, par_err and frm_err SHALL be loaded and valid SHALL be 1; latency from T0 is H+5*CLKS_PER_BIT+1 cycles.
REQ-019 After the stop sample, the FSM SHALL go to IDLE if stop = 1, else to BREAK.
REQ-020 BREAK SHALL stay until rx = 1 is sampled, then go to IDLE; start detection is disarmed while in BREAK.
REQ-021 A frame is delivered even with par_err or frm_err set.
REQ-022 valid, data and flags SHALL hold stable while valid = 1 and ready = 0.
REQ-023 A handshake without a new load SHALL clear valid and overrun the next cycle.
REQ-024 A load while valid = 1 and ready = 0 SHALL overwrite the held frame and set overrun.
REQ-025 A load in the same cycle as a handshake SHALL keep valid = 1 and leave overrun clear.
REQ-026 overrun SHALL be sticky until the next handshake.
REQ-027 The receiver SHALL accept back-to-back frames: a start edge in the cycle after the stop sample is detected.

Reset
REQ-028 While reset = 1: FSM = IDLE; counters = 0; data = 3'b000; par_err, frm_err, valid, overrun = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame and any held frame.
REQ-030 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-031 FSM state encodings and the default CLKS_PER_BIT value SHALL live in shared package par_pkg, reused by the matching transmitter.
REQ-032 The expected parity SHALL be computed by one instance of the existing xnor_i3 gate module; no other sub-modules.

Verification
REQ-033 CLKS_PER_BIT=4, frame 0,1,0,1,1,1 (data 3'b101, p=1) -> valid=1 at T0+23, data=3'b101, par_err=0, frm_err=0.
REQ-034 Same frame with p=0 -> data=3'b101, par_err=1, frm_err=0.
REQ-035 Same frame with stop=0, rx then held low 8 cycles -> frm_err=1, FSM in BREAK, and no new start is detected until rx returns high.
REQ-036 rx low 1 cycle, then high -> FSM returns to IDLE at T0+2, valid stays 0.
REQ-037 Two frames 3'b011 then 3'b110 with ready=0 -> data=3'b110 and overrun=1; a ready pulse clears valid and overrun the next cycle.
REQ-038 reset pulsed at T0+10 mid-frame -> all outputs 0 and no valid for that frame; the next clean frame is received correctly.
